// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide on operand magnitudes.
// Optional MDU_DIVZERO_FAST_EN: a divide by zero finishes on the accepting edge instead of iterating.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  // Handshake: start is sampled only while busy=0. Operands must be stable on that edge.
  // done pulses for one cycle when hi/lo become valid. flush aborts on any edge while busy.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic             accept;
  logic             sgn_in;
  logic             fast_zero;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   div_diff;
  logic             div_borrow;
  logic [WIDTH-1:0] rem_nxt;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  assign accept = (state == S_IDLE) && start && !flush;
  assign sgn_in = ~op[0];
  assign mag_a  = (sgn_in && a[WIDTH-1]) ? -a : a;
  assign mag_b  = (sgn_in && b[WIDTH-1]) ? -b : b;

`ifdef MDU_DIVZERO_FAST_EN
  assign fast_zero = op[1] && (b == '0);
`else
  assign fast_zero = 1'b0;
`endif

  // Multiply step: conditional add into the upper half, then shift {carry,hi,lo} right.
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);

  // Divide step: rem stays below the divisor, so bit W of the difference is the borrow.
  assign rem_sh     = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff   = rem_sh - {1'b0, opnd};
  assign div_borrow = div_diff[WIDTH];
  assign rem_nxt    = div_borrow ? rem_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];

  assign prod_neg = -{acc_hi, acc_lo};
  assign quo_fix  = neg_q ? -acc_lo : acc_lo;
  assign rem_fix  = neg_r ? -acc_hi : acc_hi;
  assign res_hi   = is_div ? rem_fix : (neg_q ? prod_neg[2*WIDTH-1:WIDTH] : acc_hi);
  assign res_lo   = is_div ? quo_fix : (neg_q ? prod_neg[WIDTH-1:0] : acc_lo);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = fast_zero ? S_DONE : S_CALC;
      S_CALC: begin
        if (flush)               state_nxt = S_IDLE;
        else if (cnt == CNT_ONE) state_nxt = S_SIGN;
      end
      S_SIGN:  state_nxt = flush ? S_IDLE : S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    dbg_state = state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      opnd   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt    <= CNT_INIT;
            is_div <= op[1];
            neg_q  <= sgn_in && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r  <= sgn_in && a[WIDTH-1];
            opnd   <= op[1] ? mag_b : mag_a;
            acc_hi <= '0;
            acc_lo <= op[1] ? mag_a : mag_b;
            if (fast_zero) begin
              hi <= a;
              lo <= '1;
            end
          end
        end
        S_CALC: begin
          cnt <= cnt - CNT_ONE;
          if (is_div) begin
            acc_hi <= rem_nxt;
            acc_lo <= {acc_lo[WIDTH-2:0], ~div_borrow};
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
        end
        S_SIGN: begin
          if (!flush) begin
            hi <= res_hi;
            lo <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
